// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the MEM pipeline stage and a word-wide data_memory. The pipeline
// issues byte/half/word loads and stores; the unit only ever talks to memory
// with aligned full-word reads and writes. Sub-word loads pick a lane out of
// the returned word and sign/zero-extend it. Sub-word stores perform a
// read-modify-write. Misaligned, out-of-range and reserved-encoding accesses
// fault without touching memory.
//
// Ports
//   clock, reset       : clock, asynchronous active-high reset
//   cpu_read[3:0]      : [3] load enable, [2:0] funct3 (LB/LH/LW/LBU/LHU)
//   cpu_write[2:0]     : [2] store enable, [1:0] size (SB/SH/SW)
//   cpu_address        : byte address
//   cpu_writedata      : store data (low byte/half used for SB/SH)
//   cpu_readdata       : registered, extended load result
//   cpu_busywait       : stall request to the pipeline
//   misaligned_fault   : one-cycle pulse for a faulted access
//   mem_read/mem_write : word read/write commands to data_memory
//   mem_address        : word-aligned address
//   mem_writedata      : full word to write
//   mem_readdata       : word returned by data_memory
//   mem_busywait       : memory stall, holds the current state while high
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_BYTES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  cpu_read,
  input  logic [2:0]  cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_busywait,
  output logic        misaligned_fault,
  output logic [3:0]  mem_read,
  output logic [2:0]  mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        mrd_q, mrd_d;
  logic        mwr_q, mwr_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;

  // Request fields captured in IDLE; only what later states need is kept.
  logic [1:0]  lane_q;
  logic [2:0]  funct_q;
  logic [15:0] wdata_q;
  logic        latch_en;

  logic req_ld, req_st, req_any, req_fault;

  // Fault check for a request presented in IDLE.
  function automatic logic check_fault(input logic        is_ld,
                                       input logic [2:0]  f3,
                                       input logic [1:0]  sz,
                                       input logic [31:0] a);
    logic bad;
    bad = 1'b0;
    if (is_ld) begin
      case (f3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = a[0];
        3'b010:         bad = |a[1:0];
        default:        bad = 1'b1;
      endcase
    end else begin
      case (sz)
        2'b00:   bad = 1'b0;
        2'b01:   bad = a[0];
        2'b10:   bad = |a[1:0];
        default: bad = 1'b1;
      endcase
    end
    // Range uses the last byte of the containing word so any lane past the
    // end of memory faults, regardless of access size.
    if ({a[31:2], 2'b11} >= MEM_LIMIT) bad = 1'b1;
    return bad;
  endfunction

  // Lane extraction with sign or zero extension for loads.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0]        byte_sh, half_sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    byte_sh = word >> {lane, 3'b000};
    half_sh = word >> {lane[1], 4'b0000};
    b_s     = byte_sh[7:0];
    h_s     = half_sh[15:0];
    case (f3)
      3'b000:  ext_s = b_s;
      3'b001:  ext_s = h_s;
      3'b100:  ext_s = {24'h0, byte_sh[7:0]};
      3'b101:  ext_s = {16'h0, half_sh[15:0]};
      default: ext_s = word;
    endcase
    return ext_s;
  endfunction

  // Replace the addressed byte or half of the read word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  lane,
                                              input logic        is_half);
    logic [31:0] w;
    w = word;
    if (is_half) begin
      if (lane[1]) w[31:16] = wd;
      else         w[15:0]  = wd;
    end else begin
      case (lane)
        2'd0: w[7:0]   = wd[7:0];
        2'd1: w[15:8]  = wd[7:0];
        2'd2: w[23:16] = wd[7:0];
        2'd3: w[31:24] = wd[7:0];
        default: w = word;
      endcase
    end
    return w;
  endfunction

  // Exactly one of load/store enables forms a request; both or neither is a no-op.
  assign req_ld    = cpu_read[3] & ~cpu_write[2];
  assign req_st    = cpu_write[2] & ~cpu_read[3];
  assign req_any   = req_ld | req_st;
  assign req_fault = check_fault(req_ld, cpu_read[2:0], cpu_write[1:0], cpu_address);

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    fault_d      = 1'b0;
    mrd_d        = mrd_q;
    mwr_d        = mwr_q;
    maddr_d      = maddr_q;
    mwdata_d     = mwdata_q;
    latch_en     = 1'b0;
    cpu_busywait = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          cpu_busywait = 1'b1;
          latch_en     = 1'b1;
          if (req_fault) begin
            state_d = DONE;
            fault_d = 1'b1;
            if (req_ld) rdata_d = 32'h0;
          end else begin
            maddr_d = {cpu_address[31:2], 2'b00};
            if (req_ld) begin
              state_d = LD_REQ;
              mrd_d   = 1'b1;
            end else if (cpu_write[1:0] == 2'b10) begin
              state_d  = ST_WRITE;
              mwr_d    = 1'b1;
              mwdata_d = cpu_writedata;
            end else begin
              state_d = ST_READ;
              mrd_d   = 1'b1;
            end
          end
        end
      end
      LD_REQ: begin
        cpu_busywait = 1'b1;
        if (!mem_busywait) begin
          rdata_d = load_extend(mem_readdata, lane_q, funct_q);
          mrd_d   = 1'b0;
          state_d = DONE;
        end
      end
      ST_READ: begin
        cpu_busywait = 1'b1;
        if (!mem_busywait) begin
          mwdata_d = store_merge(mem_readdata, wdata_q, lane_q, funct_q[0]);
          mrd_d    = 1'b0;
          mwr_d    = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cpu_busywait = 1'b1;
        if (!mem_busywait) begin
          mwr_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Unconditional return so an unchanged request is serviced once per pass.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (latch_en) begin
      lane_q  <= cpu_address[1:0];
      funct_q <= req_ld ? cpu_read[2:0] : {1'b0, cpu_write[1:0]};
      wdata_q <= cpu_writedata[15:0];
    end
  end

  assign cpu_readdata     = rdata_q;
  assign misaligned_fault = fault_q;
  assign mem_read         = mrd_q ? 4'b1010 : 4'b0000;
  assign mem_write        = mwr_q ? 3'b110 : 3'b000;
  assign mem_address      = maddr_q;
  assign mem_writedata    = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic [3:0]  cpu_read;
  logic [2:0]  cpu_write;
  logic [31:0] cpu_address;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_busywait;
  logic        misaligned_fault;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int n_checks = 0;
  int n_fail   = 0;

  // Word memory model, 10 words = 40 bytes.
  logic [31:0] mem [0:9];
  logic [3:0]  widx;
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  load_store_unit #(.MEM_BYTES(40)) dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait),
    .misaligned_fault(misaligned_fault),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign widx = mem_address[5:2];
  assign mem_readdata = (widx < 4'd10) ? mem[widx] : 32'h0;

  always @(posedge clock) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_write[2] && !mem_busywait && widx < 4'd10) mem[widx] <= mem_writedata;
    if (mem_read[3] && !mem_busywait) rd_cnt <= rd_cnt + 1;
    if (mem_write[2] && !mem_busywait) wr_cnt <= wr_cnt + 1;
  end

  task automatic preset(input logic [3:0] idx, input logic [31:0] v);
    pre_idx = idx; pre_val = v; pre_en = 1'b1;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  // Present a request at posedge+1 in IDLE, count busy cycles, sample in DONE.
  task automatic do_req(input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int busy, output logic flt, output logic [31:0] rdat);
    cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_writedata = wd;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cpu_busywait) begin
        busy++;
        @(posedge clock); #1;
      end else break;
    end
    flt  = misaligned_fault;
    rdat = cpu_readdata;
    cpu_read = 4'b0; cpu_write = 3'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    n_checks++; if (cpu_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_readdata: got %h expected 0", cpu_readdata); end
    n_checks++; if (misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", misaligned_fault); end
    n_checks++; if (mem_read !== 4'b0 || mem_write !== 3'b0) begin n_fail++; $display("FAIL rst_memcmd: got rd %b wr %b expected 0", mem_read, mem_write); end
    n_checks++; if (mem_address !== 32'h0 || mem_writedata !== 32'h0) begin n_fail++; $display("FAIL rst_memaddr: got %h/%h expected 0", mem_address, mem_writedata); end
    n_checks++; if (cpu_busywait !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", cpu_busywait); end
  endtask

  task automatic test_loads();
    int b; logic f; logic [31:0] r; int rd0, wr0;
    preset(4'd2, 32'h8899AABB);
    preset(4'd9, 32'h01020384);
    do_req(4'b1000, 3'b0, 32'h09, 32'h0, b, f, r);
    n_checks++; if (r !== 32'hFFFFFFAA || f !== 1'b0) begin n_fail++; $display("FAIL lb_09: got %h fault %b expected ffffffaa fault 0", r, f); end
    do_req(4'b1100, 3'b0, 32'h09, 32'h0, b, f, r);
    n_checks++; if (r !== 32'h000000AA) begin n_fail++; $display("FAIL lbu_09: got %h expected 000000aa", r); end
    do_req(4'b1001, 3'b0, 32'h0A, 32'h0, b, f, r);
    n_checks++; if (r !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh_0a: got %h expected ffff8899", r); end
    do_req(4'b1101, 3'b0, 32'h08, 32'h0, b, f, r);
    n_checks++; if (r !== 32'h0000AABB) begin n_fail++; $display("FAIL lhu_08: got %h expected 0000aabb", r); end
    do_req(4'b1000, 3'b0, 32'h0B, 32'h0, b, f, r);
    n_checks++; if (r !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_0b: got %h expected ffffff88", r); end
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req(4'b1010, 3'b0, 32'h08, 32'h0, b, f, r);
    n_checks++; if (r !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_08: got %h expected 8899aabb", r); end
    n_checks++; if (b !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", b); end
    n_checks++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL lw_access: got rd %0d wr %0d expected 1/0", rd_cnt - rd0, wr_cnt - wr0); end
    do_req(4'b1010, 3'b0, 32'h24, 32'h0, b, f, r);
    n_checks++; if (r !== 32'h01020384 || f !== 1'b0) begin n_fail++; $display("FAIL lw_last_word: got %h fault %b expected 01020384 fault 0", r, f); end
  endtask

  task automatic test_stores();
    int b; logic f; logic [31:0] r; int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req(4'b0, 3'b100, 32'h0A, 32'h0000005A, b, f, r);
    n_checks++; if (mem[2] !== 32'h885AAABB) begin n_fail++; $display("FAIL sb_word: got %h expected 885aaabb", mem[2]); end
    n_checks++; if (b !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d expected 3", b); end
    n_checks++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin n_fail++; $display("FAIL sb_access: got rd %0d wr %0d expected 1/1", rd_cnt - rd0, wr_cnt - wr0); end
    n_checks++; if (r !== 32'h01020384) begin n_fail++; $display("FAIL sb_keeps_readdata: got %h expected 01020384", r); end
    do_req(4'b0, 3'b101, 32'h0A, 32'hFFFF1234, b, f, r);
    n_checks++; if (mem[2] !== 32'h1234AABB) begin n_fail++; $display("FAIL sh_word: got %h expected 1234aabb", mem[2]); end
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req(4'b0, 3'b110, 32'h08, 32'hDEADBEEF, b, f, r);
    n_checks++; if (mem[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_word: got %h expected deadbeef", mem[2]); end
    n_checks++; if (b !== 2 || rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 1) begin n_fail++; $display("FAIL sw_access: got busy %0d rd %0d wr %0d expected 2/0/1", b, rd_cnt - rd0, wr_cnt - wr0); end
    do_req(4'b0, 3'b100, 32'h27, 32'h00000077, b, f, r);
    n_checks++; if (mem[9] !== 32'h77020384 || f !== 1'b0) begin n_fail++; $display("FAIL sb_last_byte: got %h fault %b expected 77020384 fault 0", mem[9], f); end
  endtask

  task automatic test_faults();
    int b; logic f; logic [31:0] r; int rd0, wr0;
    do_req(4'b1010, 3'b0, 32'h08, 32'h0, b, f, r);
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req(4'b1010, 3'b0, 32'h06, 32'h0, b, f, r);
    n_checks++; if (f !== 1'b1 || r !== 32'h0 || b !== 1) begin n_fail++; $display("FAIL lw_misaligned: got fault %b data %h busy %0d expected 1/0/1", f, r, b); end
    @(negedge clock);
    n_checks++; if (misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL fault_pulse: got %b expected 0", misaligned_fault); end
    @(posedge clock); #1;
    do_req(4'b1000, 3'b0, 32'h08, 32'h0, b, f, r);
    n_checks++; if (r !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL lb_08: got %h expected ffffffef", r); end
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req(4'b0, 3'b101, 32'h03, 32'h0000ABCD, b, f, r);
    n_checks++; if (f !== 1'b1 || r !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL sh_misaligned: got fault %b data %h expected 1/ffffffef", f, r); end
    do_req(4'b0, 3'b110, 32'h28, 32'h12345678, b, f, r);
    n_checks++; if (f !== 1'b1 || b !== 1) begin n_fail++; $display("FAIL sw_range: got fault %b busy %0d expected 1/1", f, b); end
    do_req(4'b1011, 3'b0, 32'h08, 32'h0, b, f, r);
    n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL ld_reserved: got %b expected 1", f); end
    do_req(4'b1000, 3'b0, 32'h28, 32'h0, b, f, r);
    n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL lb_range: got %b expected 1", f); end
    do_req(4'b0, 3'b111, 32'h08, 32'h0, b, f, r);
    n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL st_reserved: got %b expected 1", f); end
    n_checks++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL fault_no_access: got rd %0d wr %0d expected 0/0", rd_cnt - rd0, wr_cnt - wr0); end
  endtask

  task automatic test_stall();
    int b; logic f; logic [31:0] r;
    fork
      do_req(4'b1001, 3'b0, 32'h0A, 32'h0, b, f, r);
      begin
        mem_busywait = 1'b1;
        repeat (4) @(posedge clock);
        #1 mem_busywait = 1'b0;
      end
    join
    n_checks++; if (b !== 5 || r !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL ld_stall: got busy %0d data %h expected 5/ffffdead", b, r); end
  endtask

  task automatic test_conflict();
    int b; logic f; logic [31:0] r; int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req(4'b1010, 3'b110, 32'h08, 32'h0, b, f, r);
    @(posedge clock); #1;
    n_checks++; if (b !== 0 || f !== 1'b0 || rd_cnt != rd0 || wr_cnt != wr0) begin n_fail++; $display("FAIL both_enables: got busy %0d fault %b rd %0d wr %0d expected 0/0/0/0", b, f, rd_cnt - rd0, wr_cnt - wr0); end
  endtask

  task automatic test_reset_mid();
    int b; logic f; logic [31:0] r; int wr0;
    preset(4'd4, 32'h11223344);
    wr0 = wr_cnt;
    mem_busywait = 1'b1;
    cpu_read = 4'b0; cpu_write = 3'b100; cpu_address = 32'h10; cpu_writedata = 32'h000000EE;
    @(posedge clock); #1;
    n_checks++; if (mem_read !== 4'b1010) begin n_fail++; $display("FAIL st_read_cmd: got %b expected 1010", mem_read); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (mem_read !== 4'b0 || mem_write !== 3'b0) begin n_fail++; $display("FAIL reset_mid_cmd: got rd %b wr %b expected 0/0", mem_read, mem_write); end
    cpu_write = 3'b0; mem_busywait = 1'b0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (mem[4] !== 32'h11223344 || wr_cnt != wr0) begin n_fail++; $display("FAIL reset_mid_word: got %h writes %0d expected 11223344/0", mem[4], wr_cnt - wr0); end
    do_req(4'b1100, 3'b0, 32'h11, 32'h0, b, f, r);
    n_checks++; if (r !== 32'h00000033 || b !== 2) begin n_fail++; $display("FAIL after_reset_load: got %h busy %0d expected 00000033/2", r, b); end
  endtask

  initial begin
    reset = 1'b1; cpu_read = 4'b0; cpu_write = 3'b0; cpu_address = 32'h0;
    cpu_writedata = 32'h0; mem_busywait = 1'b0;
    pre_en = 1'b0; pre_idx = 4'd0; pre_val = 32'h0;
    #12;
    test_reset();
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    test_loads();
    test_stores();
    test_faults();
    test_stall();
    test_conflict();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and data_memory.
- Accepts byte, half and word load/store requests from the pipeline and stalls the pipeline with busywait while an access is in progress.
- Issues only word-aligned, full-word reads and writes to data_memory.
- Performs load byte-lane extraction with sign or zero extension, read-modify-write for sub-word stores, and alignment and range checking.

Parameters:
MEM_BYTES, 40, byte size of data_memory; any access touching a byte at or beyond MEM_BYTES faults.

Ports:
clock  input  1  system clock; all state changes on posedge.
reset  input  1  asynchronous, active-high reset.
cpu_read  input  4  [3]=load enable; [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
cpu_write  input  3  [2]=store enable; [1:0]=size (00 SB, 01 SH, 10 SW).
cpu_address  input  32  byte address.
cpu_writedata  input  32  store data; the low byte or half is used for SB/SH.
cpu_readdata  output  32  extended load result, registered.
cpu_busywait  output  1  stall request to the pipeline.
misaligned_fault  output  1  one-cycle pulse for a faulted access (misaligned, out of range, or reserved encoding).
mem_read  output  4  to data_memory; {1'b1,3'b010} when reading, else 0.
mem_write  output  3  to data_memory; {1'b1,2'b10} when writing, else 0.
mem_address  output  32  word-aligned address {addr[31:2],2'b00}.
mem_writedata  output  32  full merged word.
mem_readdata  input  32  word from data_memory.
mem_busywait  input  1  memory stall; holds the current state while high.

Behaviour:
- Reset (async) values: state=IDLE, cpu_readdata=0, misaligned_fault=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
- cpu_busywait is combinational:
  - 1 when state is IDLE and a valid request is present;
  - 1 in LD_REQ, ST_READ and ST_WRITE;
  - 0 in DONE and otherwise.
- IDLE:
  - Request = exactly one of cpu_read[3] or cpu_write[2]. Both high or neither high: no-op, no busywait, no fault.
  - On a request, latch address, funct/size, writedata and direction.
  - Check: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, reserved load funct3 (011/110/111), write size 11, or {addr[31:2],2'b11} >= MEM_BYTES → fault → DONE, with no memory access.
  - Otherwise: load → LD_REQ; SW → ST_WRITE; SB/SH → ST_READ.
- LD_REQ:
  - Drive mem_read.
  - When mem_busywait=0: capture the lane from mem_readdata, extend it, write cpu_readdata, go to DONE.
- Lane select:
  - Byte = bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Half = bits [16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- ST_READ:
  - Drive mem_read.
  - When mem_busywait=0: build mem_writedata = mem_readdata with the target byte/half lane replaced by cpu_writedata[7:0]/[15:0], then go to ST_WRITE.
- ST_WRITE:
  - Drive mem_write for exactly one cycle once mem_busywait=0, then go to DONE.
  - For SW, mem_writedata = latched writedata.
  - mem_address stays stable from the request cycle through ST_WRITE.
- DONE:
  - cpu_busywait=0; the pipeline advances on this edge.
  - misaligned_fault=1 only if the access faulted.
  - Faulted loads return cpu_readdata=0; stores leave cpu_readdata unchanged.
  - Next state is IDLE unconditionally, so each request is serviced once even if inputs are unchanged.
- Latency (with mem_busywait=0), cycles from request to busywait low:
  - load: 2;
  - SW: 2;
  - SB/SH: 3;
  - fault: 1.
  - Each mem_busywait cycle adds one cycle.
- Reset mid-access: state returns to IDLE immediately. mem_write deasserts asynchronously, so no partial store is issued.

Test Plan:
- Memory word at 0x08 = 0x8899AABB.
  - LB 0x09 → cpu_readdata=0xFFFFFFAA.
  - LBU 0x09 → 0x000000AA.
  - LH 0x0A → 0xFFFF8899.
  - LW 0x08 → 0x8899AABB, with busywait high for exactly 2 cycles.
- SB 0x5A to 0x0A on 0x8899AABB → one mem_read then one mem_write; word becomes 0x885AAABB; busywait high for 3 cycles.
- SH 0x1234 to 0x0A → word 0x1234AABB; SW 0xDEADBEEF to 0x08 → one mem_write only, no mem_read.
- LW 0x06, SH 0x03, and SW 0x28 (MEM_BYTES=40) → misaligned_fault pulses once each; mem_read/mem_write stay 0; the LW returns 0.
- mem_busywait held high 3 cycles during LD_REQ → busywait is extended by 3 cycles and the data is still correct; cpu_read and cpu_write both high → no access, no busywait.
- Assert reset during ST_READ of an SB → mem_read/mem_write drop to 0 immediately and the memory word is unchanged; the next request is serviced normally.
